// File: rtl/regfile_2r1w.sv
// WIDTH x 2**AW register file: one synchronous write port, two combinational read ports, sequential bulk clear.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w #(
    parameter int WIDTH    = 6,
    parameter int AW       = 2,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ws,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    input  logic             clr,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy
);
    localparam int DEPTH = 2**AW;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                        state_q, state_d;
    logic   [AW-1:0]               ptr_q, ptr_d;
    logic   [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                          wr_acc;
    logic                          zero_waddr;

    assign zero_waddr = (ZERO_REG != 0) && (waddr == '0);
    assign wr_acc     = ws && (state_q == IDLE) && !clr && !zero_waddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                // ptr wraps to 0 naturally on the last entry
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam logic [AW-1:0] IDX = AW'(e);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[e] <= '0;
            end else if ((state_q == CLEAR) && (ptr_q == IDX)) begin
                mem_q[e] <= '0;
            end else if (wr_acc && (waddr == IDX)) begin
                mem_q[e] <= wd;
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] data;
        data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
        // Forward only accepted writes; dropped writes never reach a reader
        if (wr_acc && (waddr == addr)) data = wd;
`endif
        if ((ZERO_REG != 0) && (addr == '0)) data = '0;
        return data;
    endfunction

    always_comb begin
        rd1 = read_port(raddr1);
        rd2 = read_port(raddr2);
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w: vector table plus hand sequences for clear, priority and reset.
module tb_regfile_2r1w;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ws, clr;
    logic [1:0] waddr, raddr1, raddr2;
    logic [5:0] wd;
    logic [5:0] rd1, rd2, rd1_z, rd2_z;
    logic       busy, busy_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(6), .AW(2), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .ws(ws), .waddr(waddr), .wd(wd),
        .raddr1(raddr1), .raddr2(raddr2), .clr(clr),
        .rd1(rd1), .rd2(rd2), .busy(busy)
    );

    regfile_2r1w #(.WIDTH(6), .AW(2), .ZERO_REG(1)) u_zr (
        .clk(clk), .rst_n(rst_n), .ws(ws), .waddr(waddr), .wd(wd),
        .raddr1(raddr1), .raddr2(raddr2), .clr(clr),
        .rd1(rd1_z), .rd2(rd2_z), .busy(busy_z)
    );

    typedef struct {
        logic       ws;
        logic [1:0] waddr;
        logic [5:0] wd;
        logic [1:0] ra1;
        logic [1:0] ra2;
        logic [5:0] e1;
        logic [5:0] e2;
        logic       ebusy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ws = 1'b0; clr = 1'b0; waddr = '0; wd = '0;
    endtask

    task automatic write(input logic [1:0] a, input logic [5:0] d);
        ws = 1'b1; waddr = a; wd = d;
        next_cycle();
        ws = 1'b0;
    endtask

    task automatic fill_pattern();
        write(2'd0, 6'h11);
        write(2'd1, 6'h22);
        write(2'd2, 6'h33);
        write(2'd3, 6'h00);
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 4; a++) begin
            raddr1 = 2'(a); raddr2 = 2'(3 - a);
            #1;
            chk({name, "_rd1"}, {2'b0, rd1}, 8'h00);
            chk({name, "_rd2"}, {2'b0, rd2}, 8'h00);
        end
        chk({name, "_busy"}, {7'b0, busy}, 8'h00);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd0, 6'h00, 2'd0, 2'd3, 6'h00, 6'h00, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 6'h00, 2'd1, 2'd2, 6'h00, 6'h00, 1'b0};
        vecs[2] = '{1'b1, 2'd1, 6'h2A, 2'd3, 2'd0, 6'h00, 6'h00, 1'b0};
        vecs[3] = '{1'b1, 2'd2, 6'h15, 2'd1, 2'd3, 6'h2A, 6'h00, 1'b0};
        vecs[4] = '{1'b0, 2'd0, 6'h00, 2'd1, 2'd2, 6'h2A, 6'h15, 1'b0};
        vecs[5] = '{1'b0, 2'd0, 6'h00, 2'd1, 2'd1, 6'h2A, 6'h2A, 1'b0};
        vecs[6] = '{1'b1, 2'd3, 6'h05, 2'd2, 2'd2, 6'h15, 6'h15, 1'b0};
        vecs[7] = '{1'b0, 2'd0, 6'h00, 2'd3, 2'd0, 6'h05, 6'h00, 1'b0};

        idle_inputs();
        raddr1 = '0; raddr2 = '0;
        rst_n = 1'b0;
        repeat (2) next_cycle();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            ws = vecs[i].ws; waddr = vecs[i].waddr; wd = vecs[i].wd;
            raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
            @(negedge clk);
            chk($sformatf("vec%0d_rd1", i), {2'b0, rd1}, {2'b0, vecs[i].e1});
            chk($sformatf("vec%0d_rd2", i), {2'b0, rd2}, {2'b0, vecs[i].e2});
            chk($sformatf("vec%0d_busy", i), {7'b0, busy}, {7'b0, vecs[i].ebusy});
            next_cycle();
        end
        idle_inputs();

        // Same-cycle read/write on addr 3 (holds 05)
        ws = 1'b1; waddr = 2'd3; wd = 6'h3F; raddr1 = 2'd3;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("rw_same_cycle", {2'b0, rd1}, 8'h3F);
`else
        chk("rw_same_cycle", {2'b0, rd1}, 8'h05);
`endif
        next_cycle();
        ws = 1'b0;
        @(negedge clk);
        chk("rw_next_cycle", {2'b0, rd1}, 8'h3F);
        next_cycle();

        // Bulk clear with dropped write during busy
        fill_pattern();
        clr = 1'b1;
        @(negedge clk);
        chk("clr_cycle_busy", {7'b0, busy}, 8'h00);
        next_cycle();
        clr = 1'b0;
        ws = 1'b1; waddr = 2'd0; wd = 6'h3C; raddr1 = 2'd0; raddr2 = 2'd1;
        @(negedge clk);
        chk("clear_c1_busy", {7'b0, busy}, 8'h01);
        chk("clear_c1_nofwd", {2'b0, rd1}, 8'h11);
        chk("clear_c1_addr1", {2'b0, rd2}, 8'h22);
        next_cycle();
        ws = 1'b0; raddr1 = 2'd3; raddr2 = 2'd2;
        @(negedge clk);
        chk("clear_c2_busy", {7'b0, busy}, 8'h01);
        chk("clear_c2_addr3", {2'b0, rd1}, 8'h00);
        chk("clear_c2_addr2", {2'b0, rd2}, 8'h33);
        raddr1 = 2'd0;
        #1;
        chk("clear_c2_addr0", {2'b0, rd1}, 8'h00);
        next_cycle();
        for (int c = 3; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("clear_c%0d_busy", c), {7'b0, busy}, 8'h01);
            next_cycle();
        end
        @(negedge clk);
        chk("clear_done_busy", {7'b0, busy}, 8'h00);
        check_all_zero("after_clear");
        next_cycle();

        // clr beats ws in IDLE; second clr in CLEAR neither restarts nor extends
        write(2'd1, 6'h2A);
        clr = 1'b1; ws = 1'b1; waddr = 2'd1; wd = 6'h2A;
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 6; c++) begin
            clr = (c == 2);
            @(negedge clk);
            chk($sformatf("prio_c%0d_busy", c), {7'b0, busy}, {7'b0, (c <= 4)});
            next_cycle();
        end
        clr = 1'b0;
        raddr1 = 2'd1;
        #1;
        chk("prio_addr1", {2'b0, rd1}, 8'h00);

        // Reset in CLEAR cycle 2 aborts at once
        fill_pattern();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("midclr_busy_before", {7'b0, busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("midclr_busy_rst", {7'b0, busy}, 8'h00);
        next_cycle();
        rst_n = 1'b1;
        check_all_zero("midclr_after");
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            chk($sformatf("midclr_idle%0d", c), {7'b0, busy}, 8'h00);
        end

        // ZERO_REG instance: entry 0 is hardwired, entry 1 is ordinary
        ws = 1'b1; waddr = 2'd0; wd = 6'h3F; raddr1 = 2'd0; raddr2 = 2'd0;
        @(negedge clk);
        chk("zr_addr0_same", {2'b0, rd1_z}, 8'h00);
        chk("zr_addr0_same2", {2'b0, rd2_z}, 8'h00);
        next_cycle();
        ws = 1'b0;
        @(negedge clk);
        chk("zr_addr0_after", {2'b0, rd1_z}, 8'h00);
        chk("nozr_addr0_after", {2'b0, rd1}, 8'h3F);
        next_cycle();
        write(2'd1, 6'h3F);
        raddr1 = 2'd1;
        @(negedge clk);
        chk("zr_addr1", {2'b0, rd1_z}, 8'h3F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the 1x1 storage cell: a WIDTH x 2**AW register file for the 6-bit CPU datapath.
- One synchronous write port and two independent asynchronous read ports.
- Built-in sequential bulk-clear engine, optional hardwired-zero entry 0, optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- WIDTH, 6, data width in bits.
- AW, 2, address width; DEPTH = 2**AW entries.
- ZERO_REG, 0, when 1 entry 0 always reads 0 and is never written.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ws  input  1  write strobe; write wd to mem[waddr] at rising clk.
- waddr  input  AW  write address.
- wd  input  WIDTH  write data.
- raddr1  input  AW  read port 1 address.
- raddr2  input  AW  read port 2 address.
- clr  input  1  start bulk-clear sequence (single-cycle pulse or level).
- rd1  output  WIDTH  read port 1 data.
- rd2  output  WIDTH  read port 2 data.
- busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset: rst_n low asynchronously zeroes every entry, FSM to IDLE, clear pointer to 0, busy=0.
- Reset outputs: rd1=rd2=0, since the array is zero.
- Reset mid-clear aborts the sequence immediately; state after release is IDLE with all entries 0.
- Reads: combinational. rdN = mem[raddrN], no clock latency.
- ZERO_REG=1 and raddrN==0: rdN=0 regardless of storage contents.
- Write accept condition: ws && state==IDLE && !clr && !(ZERO_REG && waddr==0).
- Accepted writes update mem[waddr] at the rising edge. The new value is visible on reads from the cycle after the edge.
- Writes not accepted are silently dropped: no queuing, no error flag.
- FSM states:
  - IDLE: busy=0. If clr=1 at the rising edge, go to CLEAR, ptr=0.
  - CLEAR: busy=1. Each rising edge writes 0 to mem[ptr] and increments ptr. At the edge where ptr==DEPTH-1, that entry is zeroed, ptr wraps to 0, state returns to IDLE.
- Clear timing: busy is high for exactly DEPTH cycles, starting the cycle after clr is sampled.
- clr during CLEAR is ignored; it neither restarts nor extends the sequence.
- clr and ws together in IDLE: clr wins and the write is dropped.
- Reads during CLEAR return current array contents: cleared entries read 0, not-yet-cleared entries keep their old value.
- ptr arithmetic is modulo DEPTH, AW bits wide, with no overflow flag.
- Reads on both ports to the same address are always legal and return identical data.
- Read and write to the same address in the same cycle: old value without bypass (see Optional Feature).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if a write is accepted this cycle and waddr==raddrN, rdN = wd combinationally in that same cycle (write-through forwarding). The ZERO_REG rule still forces 0 for address 0.
- Not defined: rdN always reflects stored contents; the new value appears the cycle after the write edge.
- Forwarding never occurs for dropped writes (busy, clr, or zero entry).

Test Plan:
- Reset then readback: assert rst_n=0, release; raddr1=0..3, raddr2=3..0 -> rd1=rd2=6'h00 for every address; busy=0.
- Write/dual read: write 6'h2A to addr 1 and 6'h15 to addr 2 on consecutive cycles, then raddr1=1, raddr2=2 -> rd1=6'h2A, rd2=6'h15; raddr1=raddr2=1 -> both 6'h2A.
- Same-cycle read/write: addr 3 holds 6'h05; ws=1, waddr=3, wd=6'h3F, raddr1=3:
  - without REGFILE_BYPASS_EN -> rd1=6'h05 that cycle, 6'h3F next cycle.
  - with REGFILE_BYPASS_EN -> rd1=6'h3F in the same cycle.
- Bulk clear: fill entries with 6'h11,6'h22,6'h33,6'h00; pulse clr.
  - busy high exactly 4 cycles.
  - Reading addr 3 during cycle 2 of CLEAR -> 6'h00 (pre-cleared value); reading addr 2 during cycle 2 -> 6'h33 still.
  - After busy falls, all entries read 0.
  - ws=1 to addr 0 with 6'h3C during busy -> dropped; addr 0 reads 0 afterwards.
- Priority and mid-clear reset:
  - clr and ws (addr 1, 6'h2A) in the same IDLE cycle -> addr 1 reads 0 after the clear.
  - Second clr pulse during CLEAR -> busy still lasts 4 cycles total.
  - rst_n low in CLEAR cycle 2 -> busy=0 immediately, all entries 0.
- ZERO_REG=1 build: write 6'h3F to addr 0 -> rd1 at raddr1=0 stays 6'h00. Write 6'h3F to addr 1 -> reads 6'h3F. Forwarding to addr 0 never occurs with REGFILE_BYPASS_EN defined.
